// File: rtl/coord_pkg.sv
// ---------------------------------------------------------------------------
// coord_pkg
// Shared types and constants for the coordinate gate filter.
//   DEFAULT_W / DEFAULT_N_AXIS : default coordinate width and axis count
//   state_t                    : tracking state machine encoding
//   fifo_entry_t               : output FIFO entry layout at the default size
//   REJ_MAX                    : saturation value of the reject counter
// ---------------------------------------------------------------------------
package coord_pkg;

    localparam int DEFAULT_W      = 16;
    localparam int DEFAULT_N_AXIS = 3;

    localparam logic [15:0] REJ_MAX = 16'hFFFF;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    // Field order is the FIFO word layout: coordinates in the upper bits,
    // then the re-acquisition flag, then the held flag in bit 0.
    typedef struct packed {
        logic [DEFAULT_N_AXIS*DEFAULT_W-1:0] coord;
        logic                                reacq;
        logic                                held;
    } fifo_entry_t;

endpackage

// File: rtl/coord_out_fifo.sv
// ---------------------------------------------------------------------------
// coord_out_fifo
// Synchronous FIFO holding accepted coordinate entries.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   push, push_data : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   head_data     : oldest entry, forced to zero while empty
//   full, empty   : occupancy flags derived from the registered count
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module coord_out_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

    // Storage array carries data only, so it needs no reset; the empty
    // gating on head_data keeps stale contents from leaking out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/coord_gate_filter.sv
// ---------------------------------------------------------------------------
// coord_gate_filter
// Gates N_AXIS packed coordinates against the last accepted reference with a
// per-axis absolute-delta threshold, re-acquires the track after REACQ_COUNT
// consecutive out-of-gate samples, and buffers accepted samples in an output
// FIFO.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_coord/in_valid/in_ready    : input sample handshake (axis 0 in LSBs)
//   out_coord/out_reacq/out_held  : FIFO head entry fields
//   out_valid/out_ready   : output handshake
//   rej_total             : saturating count of rejected samples
//   track_lock            : high once the track has been acquired
// Optional build macro COORD_GATE_HOLD_EN: out-of-gate samples that do not
// trigger re-acquisition push the current reference with out_held=1 instead
// of being dropped.
// ---------------------------------------------------------------------------
module coord_gate_filter
    import coord_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int N_AXIS      = DEFAULT_N_AXIS,
    parameter int THRESH      = 4,
    parameter int REACQ_COUNT = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_AXIS*W-1:0] in_coord,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N_AXIS*W-1:0] out_coord,
    output logic                out_reacq,
    output logic                out_held,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         rej_total,
    output logic                track_lock
);

    localparam int CW = N_AXIS * W;

    // Same layout as coord_pkg::fifo_entry_t, sized by this instance.
    typedef struct packed {
        logic [CW-1:0] coord;
        logic          reacq;
        logic          held;
    } entry_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] ref_coord;
    logic [CW-1:0] ref_next;
    logic [7:0]    rej_cnt;
    logic [7:0]    rej_cnt_next;
    logic [7:0]    rej_cnt_inc;
    logic [15:0]   rej_total_next;
    logic          xfer;
    logic          in_gate;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    entry_t        push_entry;
    entry_t        head_entry;

    assign in_ready    = !fifo_full;
    assign xfer        = in_valid && in_ready;
    assign rej_cnt_inc = rej_cnt + 8'd1;

    // Per-axis unsigned absolute difference, computed without wrap; the
    // sample is in-gate only if every axis is within THRESH.
    always_comb begin : gate_check
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        a       = '0;
        b       = '0;
        d       = '0;
        in_gate = 1'b1;
        for (int i = 0; i < N_AXIS; i++) begin
            a = in_coord[i*W +: W];
            b = ref_coord[i*W +: W];
            d = (a > b) ? (a - b) : (b - a);
            if (d > W'(THRESH)) begin
                in_gate = 1'b0;
            end
        end
    end

    // Next-state and push decision. Only transferred samples affect state;
    // rejected samples are always consumed.
    always_comb begin
        state_next       = state;
        ref_next         = ref_coord;
        rej_cnt_next     = rej_cnt;
        rej_total_next   = rej_total;
        push             = 1'b0;
        push_entry.coord = in_coord;
        push_entry.reacq = 1'b0;
        push_entry.held  = 1'b0;
        case (state)
            ACQUIRE: begin
                if (xfer) begin
                    push             = 1'b1;
                    push_entry.reacq = 1'b1;
                    ref_next         = in_coord;
                    rej_cnt_next     = '0;
                    state_next       = TRACK;
                end
            end
            TRACK: begin
                if (xfer) begin
                    if (in_gate) begin
                        push         = 1'b1;
                        ref_next     = in_coord;
                        rej_cnt_next = '0;
                    end else begin
                        if (rej_total != REJ_MAX) begin
                            rej_total_next = rej_total + 16'd1;
                        end
                        if (rej_cnt_inc == 8'(REACQ_COUNT)) begin
                            push             = 1'b1;
                            push_entry.reacq = 1'b1;
                            ref_next         = in_coord;
                            rej_cnt_next     = '0;
                        end else begin
                            rej_cnt_next = rej_cnt_inc;
`ifdef COORD_GATE_HOLD_EN
                            push             = 1'b1;
                            push_entry.coord = ref_coord;
                            push_entry.held  = 1'b1;
`endif
                        end
                    end
                end
            end
            default: begin
                state_next = ACQUIRE;
            end
        endcase
    end

    // State register; track_lock follows it and only reset returns to ACQUIRE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    // Reference, consecutive-reject counter and reject total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_coord <= '0;
            rej_cnt   <= '0;
            rej_total <= '0;
        end else begin
            ref_coord <= ref_next;
            rej_cnt   <= rej_cnt_next;
            rej_total <= rej_total_next;
        end
    end

    coord_out_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_ready),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_coord  = head_entry.coord;
    assign out_reacq  = head_entry.reacq;
    assign out_held   = head_entry.held;
    assign track_lock = (state == TRACK);

endmodule

// File: tb/tb_coord_gate_filter.sv
// ---------------------------------------------------------------------------
// tb_coord_gate_filter
// Self-checking bench for coord_gate_filter. A queue-based reference model
// tracks the expected FIFO contents, reference, reject counter and totals.
// Build with COORD_GATE_HOLD_EN to exercise the held-sample feature.
// ---------------------------------------------------------------------------
module tb_coord_gate_filter;

    localparam int W           = 16;
    localparam int N_AXIS      = 3;
    localparam int THRESH      = 4;
    localparam int REACQ_COUNT = 3;
    localparam int FIFO_DEPTH  = 4;
    localparam int CW          = W * N_AXIS;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic [CW-1:0] in_coord  = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [CW-1:0] out_coord;
    logic          out_reacq;
    logic          out_held;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   rej_total;
    logic          track_lock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [CW-1:0] coord;
        bit            reacq;
        bit            held;
    } ent_t;

    ent_t          mq[$];
    logic [CW-1:0] m_ref;
    int            m_cnt;
    bit            m_track;
    int            m_rej;

    coord_gate_filter #(
        .W           (W),
        .N_AXIS      (N_AXIS),
        .THRESH      (THRESH),
        .REACQ_COUNT (REACQ_COUNT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_coord   (in_coord),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_coord  (out_coord),
        .out_reacq  (out_reacq),
        .out_held   (out_held),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rej_total  (rej_total),
        .track_lock (track_lock)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] pack3(int a, int b, int c);
        logic [CW-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a);
        v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c);
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ref   = '0;
        m_cnt   = 0;
        m_track = 0;
        m_rej   = 0;
    endfunction

    function automatic bit model_in_gate(logic [CW-1:0] c);
        for (int i = 0; i < N_AXIS; i++) begin
            int x = int'(c[i*W +: W]);
            int y = int'(m_ref[i*W +: W]);
            int d = (x > y) ? x - y : y - x;
            if (d > THRESH) return 0;
        end
        return 1;
    endfunction

    // Applies the tracking rules to one transferred sample.
    function automatic void model_accept(logic [CW-1:0] c);
        if (!m_track) begin
            mq.push_back('{coord: c, reacq: 1'b1, held: 1'b0});
            m_ref   = c;
            m_cnt   = 0;
            m_track = 1;
        end else if (model_in_gate(c)) begin
            mq.push_back('{coord: c, reacq: 1'b0, held: 1'b0});
            m_ref = c;
            m_cnt = 0;
        end else begin
            if (m_rej < 65535) m_rej++;
            m_cnt++;
            if (m_cnt == REACQ_COUNT) begin
                mq.push_back('{coord: c, reacq: 1'b1, held: 1'b0});
                m_ref = c;
                m_cnt = 0;
            end else begin
`ifdef COORD_GATE_HOLD_EN
                mq.push_back('{coord: m_ref, reacq: 1'b0, held: 1'b1});
`endif
            end
        end
    endfunction

    // Drives one cycle from posedge+1 to the next posedge+1 and advances the
    // model using its own view of FIFO occupancy.
    task automatic applyStimulus(input logic [CW-1:0] c, input bit v,
                                 input bit r, output bit took);
        bit can_push;
        bit can_pop;
        in_coord  = c;
        in_valid  = v;
        out_ready = r;
        can_push  = (mq.size() < FIFO_DEPTH);
        can_pop   = (mq.size() > 0);
        @(posedge clk);
        #1;
        if (r && can_pop) mq.delete(0);
        took = v && can_push;
        if (took) model_accept(c);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %0b want 0", out_valid); end
        vectors++; if (out_coord !== '0) begin miscompares++; $display("[TB] FAIL rst_coord got %h want 0", out_coord); end
        vectors++; if (out_reacq !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_reacq got %0b want 0", out_reacq); end
        vectors++; if (out_held !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_held got %0b want 0", out_held); end
        vectors++; if (rej_total !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_rej got %0d want 0", rej_total); end
        vectors++; if (track_lock !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_lock got %0b want 0", track_lock); end
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_acquire();
        bit took;
        applyStimulus(pack3(100, 200, 300), 1'b1, 1'b0, took);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL acq_valid got %0b want 1", out_valid); end
        vectors++; if (out_coord !== pack3(100, 200, 300)) begin miscompares++; $display("[TB] FAIL acq_coord got %h want %h", out_coord, pack3(100, 200, 300)); end
        vectors++; if (out_reacq !== 1'b1) begin miscompares++; $display("[TB] FAIL acq_reacq got %0b want 1", out_reacq); end
        vectors++; if (track_lock !== 1'b1) begin miscompares++; $display("[TB] FAIL acq_lock got %0b want 1", track_lock); end
    endtask

    task automatic test_gate();
        bit took;
        applyStimulus(pack3(104, 196, 300), 1'b1, 1'b1, took);
        vectors++; if (out_coord !== pack3(104, 196, 300)) begin miscompares++; $display("[TB] FAIL gate_pass_coord got %h want %h", out_coord, pack3(104, 196, 300)); end
        vectors++; if (out_reacq !== 1'b0) begin miscompares++; $display("[TB] FAIL gate_pass_reacq got %0b want 0", out_reacq); end
        applyStimulus(pack3(109, 196, 300), 1'b1, 1'b1, took);
        vectors++; if (rej_total !== 16'd1) begin miscompares++; $display("[TB] FAIL gate_rej_total got %0d want 1", rej_total); end
        vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("[TB] FAIL gate_rej_valid got %0b want %0b", out_valid, mq.size() != 0); end
    endtask

    task automatic test_reacq();
        bit took;
        applyStimulus(pack3(105, 196, 300), 1'b1, 1'b1, took);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(pack3(500, 500, 500), 1'b1, 1'b1, took);
            vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("[TB] FAIL reacq_valid%0d got %0b want %0b", k, out_valid, mq.size() != 0); end
        end
        vectors++; if (out_coord !== pack3(500, 500, 500)) begin miscompares++; $display("[TB] FAIL reacq_coord got %h want %h", out_coord, pack3(500, 500, 500)); end
        vectors++; if (out_reacq !== 1'b1) begin miscompares++; $display("[TB] FAIL reacq_flag got %0b want 1", out_reacq); end
        vectors++; if (rej_total !== 16'(m_rej)) begin miscompares++; $display("[TB] FAIL reacq_rej got %0d want %0d", rej_total, m_rej); end
        applyStimulus(pack3(502, 500, 500), 1'b1, 1'b1, took);
        vectors++; if (out_coord !== pack3(502, 500, 500)) begin miscompares++; $display("[TB] FAIL reacq_next_coord got %h want %h", out_coord, pack3(502, 500, 500)); end
        vectors++; if (out_reacq !== 1'b0) begin miscompares++; $display("[TB] FAIL reacq_next_flag got %0b want 0", out_reacq); end
    endtask

    task automatic test_back_to_back();
        bit took;
        bit done;
        int expect_x;
        for (int k = 0; k < 8 && mq.size() != 0; k++) applyStimulus('0, 1'b0, 1'b1, took);
        for (int k = 1; k <= 4; k++) applyStimulus(pack3(502 + k, 500, 500), 1'b1, 1'b0, took);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full_ready got %0b want 0", in_ready); end
        applyStimulus(pack3(507, 500, 500), 1'b1, 1'b0, took);
        vectors++; if (out_coord !== pack3(503, 500, 500)) begin miscompares++; $display("[TB] FAIL b2b_stable got %h want %h", out_coord, pack3(503, 500, 500)); end
        expect_x = 503;
        done = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            vectors++; if (out_coord !== pack3(expect_x, 500, 500)) begin miscompares++; $display("[TB] FAIL b2b_order got %h want %h", out_coord, pack3(expect_x, 500, 500)); end
            applyStimulus(pack3(507, 500, 500), 1'b1, 1'b1, took);
            expect_x++;
            done = took;
        end
        vectors++; if (!done) begin miscompares++; $display("[TB] FAIL b2b_accept_timeout got 0 want 1"); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pushpop_ready got %0b want 1", in_ready); end
        for (int k = 0; k < 8 && mq.size() != 0; k++) begin
            vectors++; if (out_coord !== pack3(expect_x, 500, 500)) begin miscompares++; $display("[TB] FAIL b2b_drain got %h want %h", out_coord, pack3(expect_x, 500, 500)); end
            applyStimulus('0, 1'b0, 1'b1, took);
            expect_x++;
        end
        vectors++; if (expect_x !== 508) begin miscompares++; $display("[TB] FAIL b2b_count got %0d want 508", expect_x); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        bit            took;
        logic [CW-1:0] c;
        for (int n = 0; n < 400; n++) begin
            vectors++; if (out_valid !== (mq.size() != 0)) begin miscompares++; $display("[TB] FAIL rnd_valid@%0d got %0b want %0b", n, out_valid, mq.size() != 0); end
            vectors++; if (in_ready !== (mq.size() < FIFO_DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_ready@%0d got %0b want %0b", n, in_ready, mq.size() < FIFO_DEPTH); end
            vectors++; if (rej_total !== 16'(m_rej)) begin miscompares++; $display("[TB] FAIL rnd_rej@%0d got %0d want %0d", n, rej_total, m_rej); end
            vectors++; if (track_lock !== m_track) begin miscompares++; $display("[TB] FAIL rnd_lock@%0d got %0b want %0b", n, track_lock, m_track); end
            if (mq.size() != 0) begin
                vectors++; if (out_coord !== mq[0].coord) begin miscompares++; $display("[TB] FAIL rnd_coord@%0d got %h want %h", n, out_coord, mq[0].coord); end
                vectors++; if (out_reacq !== mq[0].reacq) begin miscompares++; $display("[TB] FAIL rnd_reacq@%0d got %0b want %0b", n, out_reacq, mq[0].reacq); end
                vectors++; if (out_held !== mq[0].held) begin miscompares++; $display("[TB] FAIL rnd_held@%0d got %0b want %0b", n, out_held, mq[0].held); end
            end
            c = '0;
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N_AXIS; i++) c[i*W +: W] = W'($urandom_range(0, 65535));
            end else begin
                for (int i = 0; i < N_AXIS; i++) begin
                    int x = int'(m_ref[i*W +: W]) + int'($urandom_range(0, 12)) - 6;
                    c[i*W +: W] = W'(x);
                end
            end
            applyStimulus(c, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, took);
        end
    endtask

    task automatic test_async_reset();
        bit took;
        reset_n = 1'b0;
        #4 reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        applyStimulus(pack3(1000, 1000, 1000), 1'b1, 1'b1, took);
        for (int g = 1; g <= 3; g++) begin
            applyStimulus(pack3(2000, 1000, 1000), 1'b1, 1'b1, took);
            applyStimulus(pack3(2000, 1000, 1000), 1'b1, 1'b1, took);
            applyStimulus(pack3(1000 + g, 1000, 1000), 1'b1, 1'b1, took);
        end
        applyStimulus(pack3(2000, 1000, 1000), 1'b1, 1'b1, took);
        applyStimulus(pack3(1004, 1000, 1000), 1'b1, 1'b0, took);
        applyStimulus(pack3(1005, 1000, 1000), 1'b1, 1'b0, took);
        vectors++; if (rej_total !== 16'd7) begin miscompares++; $display("[TB] FAIL arst_pre_rej got %0d want 7", rej_total); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_pre_valid got %0b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_valid got %0b want 0", out_valid); end
        vectors++; if (out_coord !== '0) begin miscompares++; $display("[TB] FAIL arst_coord got %h want 0", out_coord); end
        vectors++; if (rej_total !== 16'd0) begin miscompares++; $display("[TB] FAIL arst_rej got %0d want 0", rej_total); end
        vectors++; if (track_lock !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_lock got %0b want 0", track_lock); end
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        applyStimulus(pack3(700, 700, 700), 1'b1, 1'b0, took);
        vectors++; if (out_reacq !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_reacq got %0b want 1", out_reacq); end
        vectors++; if (out_coord !== pack3(700, 700, 700)) begin miscompares++; $display("[TB] FAIL arst_reacq_coord got %h want %h", out_coord, pack3(700, 700, 700)); end
    endtask

`ifdef COORD_GATE_HOLD_EN
    task automatic test_hold();
        bit took;
        reset_n = 1'b0;
        #4 reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        applyStimulus(pack3(100, 100, 100), 1'b1, 1'b0, took);
        applyStimulus(pack3(200, 100, 100), 1'b1, 1'b1, took);
        vectors++; if (out_coord !== pack3(100, 100, 100)) begin miscompares++; $display("[TB] FAIL hold_coord got %h want %h", out_coord, pack3(100, 100, 100)); end
        vectors++; if (out_held !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_flag got %0b want 1", out_held); end
        vectors++; if (out_reacq !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_reacq got %0b want 0", out_reacq); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_acquire();
        test_gate();
        test_reacq();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef COORD_GATE_HOLD_EN
        test_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
